// File: rtl/serial_parallel_receiver_if.sv
// Serial link plus downstream valid/ready bundle for serial_parallel_receiver.
// The slave modport is the receiver's view; master is the transmitter/consumer side.
interface serial_parallel_receiver_if #(
    parameter int WIDTH = 32
);
    logic             serial_data_in;
    logic             serial_valid;
    logic [WIDTH-1:0] parallel_data_out;
    logic             data_valid;
    logic             data_ready;

    modport slave (
        input  serial_data_in,
        input  serial_valid,
        input  data_ready,
        output parallel_data_out,
        output data_valid
    );

    modport master (
        output serial_data_in,
        output serial_valid,
        output data_ready,
        input  parallel_data_out,
        input  data_valid
    );
endinterface

// File: rtl/serial_parallel_receiver.sv
// LSB-first serial-to-parallel receiver with a valid/ready word output,
// truncated-frame detection and a sticky overrun flag.
module serial_parallel_receiver #(
    parameter int WIDTH = 32
) (
    input  logic                         i_p_clk,
    input  logic                         i_rst,
    input  logic                         i_clr_overrun,
    output logic                         o_busy,
    output logic                         o_frame_err,
    output logic                         o_overrun,
    serial_parallel_receiver_if.slave    bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             r_lost;

    logic [WIDTH-1:0] w_shift_next;
    logic             w_ovr_set;

    assign w_shift_next = {bus.serial_data_in, r_shift[WIDTH-1:1]};
    assign w_ovr_set    = (r_state == ST_HOLD) && !bus.data_ready && bus.serial_valid;

    // Frame FSM: bit capture, word hand-off and lost-frame tracking.
    always_ff @(posedge i_p_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= {CW{1'b0}};
            r_shift     <= {WIDTH{1'b0}};
            r_data      <= {WIDTH{1'b0}};
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_lost      <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.serial_valid) begin
                        r_shift   <= w_shift_next;
                        r_bit_cnt <= CW'(1);
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bus.serial_valid) begin
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_data    <= w_shift_next;
                            r_valid   <= 1'b1;
                            r_bit_cnt <= {CW{1'b0}};
                            r_state   <= ST_HOLD;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CW'(1);
                        end
                    end else begin
                        r_frame_err <= 1'b1;
                        r_bit_cnt   <= {CW{1'b0}};
                        r_state     <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (bus.data_ready) begin
                        r_valid <= 1'b0;
                        r_lost  <= 1'b0;
                        // A frame dropped during the hold must be skipped to its end.
                        if (r_lost) begin
                            r_state <= bus.serial_valid ? ST_DISCARD : ST_IDLE;
                        end else if (bus.serial_valid) begin
                            r_shift   <= w_shift_next;
                            r_bit_cnt <= CW'(1);
                            r_state   <= ST_SHIFT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (bus.serial_valid) begin
                        r_lost <= 1'b1;
                    end
                end
                ST_DISCARD: begin
                    if (!bus.serial_valid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_valid   <= 1'b0;
                    r_bit_cnt <= {CW{1'b0}};
                    r_lost    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun; a new overrun beats a simultaneous clear.
    always_ff @(posedge i_p_clk) begin
        if (i_rst) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (i_clr_overrun) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= r_overrun;
        end
    end

    assign bus.parallel_data_out = r_data;
    assign bus.data_valid        = r_valid;
    assign o_busy                = (r_state != ST_IDLE);
    assign o_frame_err           = r_frame_err;
    assign o_overrun             = r_overrun;
endmodule

// File: tb/tb_serial_parallel_receiver.sv
// Directed bench for serial_parallel_receiver: a table of single frames plus
// hand-written sequences for back-to-back, overrun, truncation and reset cases.
module tb_serial_parallel_receiver;
    localparam int W = 32;

    typedef struct {
        logic [31:0] word;
        logic [31:0] exp_word;
    } frame_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic busy;
    logic fe;
    logic ovr;
    int   tests_run = 0;
    int   tests_failed = 0;

    serial_parallel_receiver_if #(.WIDTH(W)) bus_if ();

    serial_parallel_receiver #(.WIDTH(W)) dut (
        .i_p_clk       (clk),
        .i_rst         (rst),
        .i_clr_overrun (clr),
        .o_busy        (busy),
        .o_frame_err   (fe),
        .o_overrun     (ovr),
        .bus           (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are read 1 time unit after the edge.
    task automatic tick(input logic sv, input logic sd, input logic rdy, input logic c);
        bus_if.serial_valid   = sv;
        bus_if.serial_data_in = sd;
        bus_if.data_ready     = rdy;
        clr                   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] w, input int first, input int last, input logic rdy);
        for (int i = first; i <= last; i++) begin
            tick(1'b1, w[i], rdy, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_vec_t vecs[5];
        int         fe_seen;
        int         dv_seen;

        vecs[0] = '{word: 32'hA5A5_F00F, exp_word: 32'hA5A5_F00F};
        vecs[1] = '{word: 32'hFFFF_FFFF, exp_word: 32'hFFFF_FFFF};
        vecs[2] = '{word: 32'h0000_0000, exp_word: 32'h0000_0000};
        vecs[3] = '{word: 32'h8000_0001, exp_word: 32'h8000_0001};
        vecs[4] = '{word: 32'h5555_AAAA, exp_word: 32'h5555_AAAA};

        bus_if.serial_valid   = 1'b0;
        bus_if.serial_data_in = 1'b0;
        bus_if.data_ready     = 1'b0;

        // Reset state
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_dv", bus_if.data_valid, 32'd0);
        check("rst_word", bus_if.parallel_data_out, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_fe", fe, 32'd0);
        check("rst_ovr", ovr, 32'd0);
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Single frames, ready held high
        for (int v = 0; v < 5; v++) begin
            send_bits(vecs[v].word, 0, 15, 1'b1);
            check("mid_busy", busy, 32'd1);
            check("mid_dv", bus_if.data_valid, 32'd0);
            send_bits(vecs[v].word, 16, 31, 1'b1);
            check("frm_dv", bus_if.data_valid, 32'd1);
            check("frm_word", bus_if.parallel_data_out, vecs[v].exp_word);
            check("frm_fe", fe, 32'd0);
            check("frm_ovr", ovr, 32'd0);
            tick(1'b0, 1'b0, 1'b1, 1'b0);
            check("post_dv", bus_if.data_valid, 32'd0);
            check("post_busy", busy, 32'd0);
            check("post_word_hold", bus_if.parallel_data_out, vecs[v].exp_word);
        end

        // Back-to-back frames with no gap
        send_bits(32'h0000_0001, 0, 31, 1'b1);
        check("b2b_dv1", bus_if.data_valid, 32'd1);
        check("b2b_word1", bus_if.parallel_data_out, 32'h0000_0001);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        check("b2b_accept_dv", bus_if.data_valid, 32'd0);
        check("b2b_accept_busy", busy, 32'd1);
        send_bits(32'h8000_0000, 1, 31, 1'b1);
        check("b2b_dv2", bus_if.data_valid, 32'd1);
        check("b2b_word2", bus_if.parallel_data_out, 32'h8000_0000);
        check("b2b_ovr", ovr, 32'd0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("b2b_idle", busy, 32'd0);

        // Overrun while the word is held
        send_bits(32'h1234_5678, 0, 31, 1'b0);
        check("ovr_dv", bus_if.data_valid, 32'd1);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("ovr_set", ovr, 32'd1);
        send_bits(32'hFFFF_FFFF, 1, 31, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("ovr_hold_dv", bus_if.data_valid, 32'd1);
        check("ovr_hold_word", bus_if.parallel_data_out, 32'h1234_5678);
        check("ovr_hold_busy", busy, 32'd1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("ovr_hs_dv", bus_if.data_valid, 32'd0);
        check("ovr_hs_busy", busy, 32'd0);
        check("ovr_sticky", ovr, 32'd1);
        check("ovr_word_kept", bus_if.parallel_data_out, 32'h1234_5678);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_clr", ovr, 32'd0);

        // Clear and new overrun in the same cycle, then discard rest of lost frame
        send_bits(32'h0000_FFFF, 0, 31, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("setwins_ovr", ovr, 32'd1);
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        check("disc_dv", bus_if.data_valid, 32'd0);
        check("disc_busy", busy, 32'd1);
        fe_seen = 0;
        dv_seen = 0;
        for (int i = 0; i < 21; i++) begin
            tick(1'b1, 1'b1, 1'b1, 1'b0);
            if (fe === 1'b1) fe_seen++;
            if (bus_if.data_valid === 1'b1) dv_seen++;
        end
        check("disc_no_fe", fe_seen, 32'd0);
        check("disc_no_dv", dv_seen, 32'd0);
        check("disc_still_busy", busy, 32'd1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("disc_exit_busy", busy, 32'd0);
        check("disc_exit_fe", fe, 32'd0);
        check("disc_ovr_kept", ovr, 32'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("disc_ovr_clr", ovr, 32'd0);

        // Truncated frame after 17 bits
        send_bits(32'h0001_FFFF, 0, 16, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("trunc_fe", fe, 32'd1);
        check("trunc_dv", bus_if.data_valid, 32'd0);
        check("trunc_busy", busy, 32'd0);
        check("trunc_word_kept", bus_if.parallel_data_out, 32'h0000_FFFF);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("trunc_fe_pulse", fe, 32'd0);
        send_bits(32'hDEAD_BEEF, 0, 31, 1'b1);
        check("after_trunc_dv", bus_if.data_valid, 32'd1);
        check("after_trunc_word", bus_if.parallel_data_out, 32'hDEAD_BEEF);
        tick(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a frame
        send_bits(32'h1357_9BDF, 0, 19, 1'b1);
        rst = 1'b1;
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        check("mrst_word", bus_if.parallel_data_out, 32'd0);
        check("mrst_dv", bus_if.data_valid, 32'd0);
        check("mrst_busy", busy, 32'd0);
        check("mrst_fe", fe, 32'd0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("mrst_idle", busy, 32'd0);
        dv_seen = 0;
        for (int i = 0; i < 32; i++) begin
            if (bus_if.data_valid === 1'b1) dv_seen++;
            tick(1'b1, 32'h0F0F_0F0F >> i, 1'b1, 1'b0);
        end
        check("mrst_no_early_dv", dv_seen, 32'd0);
        check("mrst_dv", bus_if.data_valid, 32'd1);
        check("mrst_word_new", bus_if.parallel_data_out, 32'h0F0F_0F0F);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("mrst_done", bus_if.data_valid, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
